// File: rtl/pll_pkg.sv
// Shared types and helpers for the PLL lock detector and related clock monitors.
// Holds the FSM state encoding, timeout derivation and the tolerance compare.
package pll_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ARM,
      MEASURE,
      LOCKED
   } pll_state_t;

   typedef struct packed {
      logic hi;
      logic lo;
   } tol_err_t;

   function automatic int unsigned tmo_of(input int unsigned mult);
      return 2 * mult;
   endfunction

   // Unsigned compare with one spare bit so MULT+TOL cannot wrap; low bound clamps at 0.
   function automatic tol_err_t in_tol(input int unsigned period,
                                       input int unsigned mult,
                                       input int unsigned tol);
      tol_err_t    r;
      logic [32:0] p;
      logic [32:0] hi_bound;
      logic [32:0] lo_bound;
      p        = {1'b0, period};
      hi_bound = 33'(mult) + 33'(tol);
      lo_bound = (mult > tol) ? 33'(mult - tol) : '0;
      r.hi     = (p > hi_bound);
      r.lo     = (p < lo_bound);
      return r;
   endfunction

endpackage

// File: rtl/ref_edge_sync.sv
// Synchronizes a slow reference clock sampled as data and emits a one-cycle
// registered pulse on each of its rising edges.
module ref_edge_sync #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic CLK,
   input  logic RST,
   input  logic Ref_Clk,
   output logic rise
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   hist_q;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         sync_q <= '0;
         hist_q <= 1'b0;
         rise   <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], Ref_Clk};
         hist_q <= sync_q[SYNC_STAGES-1];
         rise   <= sync_q[SYNC_STAGES-1] & ~hist_q;
      end
   end

endmodule

// File: rtl/pll_lock_detector.sv
// Frequency-lock monitor: measures each Ref_Clk period in CLK cycles and reports
// lock, loss of reference and per-measurement frequency error.
module pll_lock_detector
   import pll_pkg::*;
#(
   parameter int unsigned MULT        = 50,
   parameter int unsigned TOL         = 2,
   parameter int unsigned LOCK_CNT    = 4,
   parameter int unsigned UNLOCK_CNT  = 2,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned CNT_W       = 8
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             Ref_Clk,
   input  logic             en,
   output logic [CNT_W-1:0] period,
   output logic             period_valid,
   output logic             err_hi,
   output logic             err_lo,
   output logic             locked,
   output logic             ref_lost
);

   localparam int unsigned TMO    = tmo_of(MULT);
   localparam int unsigned GOOD_W = $clog2(LOCK_CNT + 1);
   localparam int unsigned BAD_W  = $clog2(UNLOCK_CNT + 1);
   localparam logic [CNT_W-1:0]  CNT_MAX     = '1;
   localparam logic [CNT_W-1:0]  CNT_TMO     = CNT_W'(TMO);
   localparam logic [GOOD_W-1:0] LOCK_LAST   = GOOD_W'(LOCK_CNT - 1);
   localparam logic [BAD_W-1:0]  UNLOCK_LAST = BAD_W'(UNLOCK_CNT - 1);

   if (!(((64'd1 << CNT_W) - 64'd1) > 64'(2 * MULT))) begin : g_bad_cnt_w
      $error("CNT_W too narrow: 2^CNT_W-1 must exceed 2*MULT");
   end
   if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("SYNC_STAGES must be at least 2");
   end

   logic              rise;
   pll_state_t        state;
   logic [CNT_W-1:0]  cnt;
   logic [GOOD_W-1:0] good_cnt;
   logic [BAD_W-1:0]  bad_cnt;
   tol_err_t          tol;
   logic              timeout;

   ref_edge_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_ref_edge_sync (
      .CLK    (CLK),
      .RST    (RST),
      .Ref_Clk(Ref_Clk),
      .rise   (rise)
   );

   always_comb begin
      tol     = in_tol(32'(cnt), MULT, TOL);
      timeout = (cnt == CNT_TMO);
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state        <= IDLE;
         cnt          <= '0;
         good_cnt     <= '0;
         bad_cnt      <= '0;
         period       <= '0;
         period_valid <= 1'b0;
         err_hi       <= 1'b0;
         err_lo       <= 1'b0;
         locked       <= 1'b0;
         ref_lost     <= 1'b0;
      end else if (!en) begin
         state        <= IDLE;
         cnt          <= '0;
         good_cnt     <= '0;
         bad_cnt      <= '0;
         period       <= '0;
         period_valid <= 1'b0;
         err_hi       <= 1'b0;
         err_lo       <= 1'b0;
         locked       <= 1'b0;
         ref_lost     <= 1'b0;
      end else begin
         period_valid <= 1'b0;
         if (state != IDLE) begin
            if (rise) begin
               cnt <= CNT_W'(1);
            end else if (cnt != CNT_MAX) begin
               cnt <= cnt + CNT_W'(1);
            end
         end
         case (state)
            IDLE: begin
               state <= ARM;
            end
            ARM: begin
               if (rise) begin
                  state    <= MEASURE;
                  ref_lost <= 1'b0;
               end
            end
            MEASURE, LOCKED: begin
               // A rise on the timeout cycle still captures; the timeout is ignored.
               if (rise) begin
                  period       <= cnt;
                  period_valid <= 1'b1;
                  err_hi       <= tol.hi;
                  err_lo       <= tol.lo;
                  ref_lost     <= 1'b0;
                  if (state == MEASURE) begin
                     if (tol.hi || tol.lo) begin
                        good_cnt <= '0;
                     end else if (good_cnt == LOCK_LAST) begin
                        state    <= LOCKED;
                        locked   <= 1'b1;
                        good_cnt <= '0;
                     end else begin
                        good_cnt <= good_cnt + GOOD_W'(1);
                     end
                  end else begin
                     if (!(tol.hi || tol.lo)) begin
                        bad_cnt <= '0;
                     end else if (bad_cnt == UNLOCK_LAST) begin
                        state    <= MEASURE;
                        locked   <= 1'b0;
                        good_cnt <= '0;
                        bad_cnt  <= '0;
                     end else begin
                        bad_cnt <= bad_cnt + BAD_W'(1);
                     end
                  end
               end else if (timeout) begin
                  state    <= ARM;
                  ref_lost <= 1'b1;
                  locked   <= 1'b0;
                  good_cnt <= '0;
                  bad_cnt  <= '0;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pll_lock_detector.sv
// Directed, table-driven bench for pll_lock_detector with default parameters
// (MULT=50, TOL=2, LOCK_CNT=4, UNLOCK_CNT=2, TMO=100).
module tb_pll_lock_detector;

   logic       CLK;
   logic       RST;
   logic       Ref_Clk;
   logic       en;
   logic [7:0] period;
   logic       period_valid;
   logic       err_hi;
   logic       err_lo;
   logic       locked;
   logic       ref_lost;

   int total = 0;
   int bad   = 0;
   int since = 0;      // CLK edges since the last Ref_Clk rising edge driven
   int last_cap = 0;   // value of 'since' when the last capture was observed

   typedef struct {
      int per;   // CLK cycles from previous Ref_Clk rise to this one
      int v;     // capture expected
      int prd;
      int hi;
      int lo;
      int lk;
      int rl;
   } vec_t;

   vec_t tbl[20];

   pll_lock_detector #(
      .MULT       (50),
      .TOL        (2),
      .LOCK_CNT   (4),
      .UNLOCK_CNT (2),
      .SYNC_STAGES(2),
      .CNT_W      (8)
   ) dut (
      .CLK         (CLK),
      .RST         (RST),
      .Ref_Clk     (Ref_Clk),
      .en          (en),
      .period      (period),
      .period_valid(period_valid),
      .err_hi      (err_hi),
      .err_lo      (err_lo),
      .locked      (locked),
      .ref_lost    (ref_lost)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #1ms;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
      since++;
      if (since == 10) Ref_Clk = 1'b0;
   endtask

   task automatic ref_rise_after(input int p);
      while (since < p) tick();
      Ref_Clk = 1'b1;
      since   = 0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_period"}, int'(period), 0);
      chk({tag, "_valid"}, int'(period_valid), 0);
      chk({tag, "_err_hi"}, int'(err_hi), 0);
      chk({tag, "_err_lo"}, int'(err_lo), 0);
      chk({tag, "_locked"}, int'(locked), 0);
      chk({tag, "_ref_lost"}, int'(ref_lost), 0);
   endtask

   task automatic apply_vec(input string tag, input vec_t v);
      int got;
      got = 0;
      ref_rise_after(v.per);
      for (int i = 0; i < 8; i++) begin
         tick();
         if (period_valid) begin
            got      = 1;
            last_cap = since;
            break;
         end
      end
      chk({tag, "_valid"}, got, v.v);
      if (got == 1) begin
         chk({tag, "_period"}, int'(period), v.prd);
         chk({tag, "_err_hi"}, int'(err_hi), v.hi);
         chk({tag, "_err_lo"}, int'(err_lo), v.lo);
      end
      chk({tag, "_locked"}, int'(locked), v.lk);
      chk({tag, "_ref_lost"}, int'(ref_lost), v.rl);
   endtask

   task automatic lock_seq(input string tag);
      vec_t v;
      v = '{50, 0, 0, 0, 0, 0, 0};
      apply_vec({tag, "_arm"}, v);
      for (int k = 0; k < 4; k++) begin
         v = '{50, 1, 50, 0, 0, (k == 3) ? 1 : 0, 0};
         apply_vec($sformatf("%s_cap%0d", tag, k), v);
      end
   endtask

   initial begin
      int seen;

      tbl[0]  = '{60,  0, 0,   0, 0, 0, 0};
      tbl[1]  = '{50,  1, 50,  0, 0, 0, 0};
      tbl[2]  = '{50,  1, 50,  0, 0, 0, 0};
      tbl[3]  = '{50,  1, 50,  0, 0, 0, 0};
      tbl[4]  = '{50,  1, 50,  0, 0, 1, 0};
      tbl[5]  = '{55,  1, 55,  1, 0, 1, 0};
      tbl[6]  = '{50,  1, 50,  0, 0, 1, 0};
      tbl[7]  = '{55,  1, 55,  1, 0, 1, 0};
      tbl[8]  = '{55,  1, 55,  1, 0, 0, 0};
      tbl[9]  = '{48,  1, 48,  0, 0, 0, 0};
      tbl[10] = '{52,  1, 52,  0, 0, 0, 0};
      tbl[11] = '{47,  1, 47,  0, 1, 0, 0};
      tbl[12] = '{50,  1, 50,  0, 0, 0, 0};
      tbl[13] = '{48,  1, 48,  0, 0, 0, 0};
      tbl[14] = '{52,  1, 52,  0, 0, 0, 0};
      tbl[15] = '{50,  1, 50,  0, 0, 1, 0};
      tbl[16] = '{53,  1, 53,  1, 0, 1, 0};
      tbl[17] = '{52,  1, 52,  0, 0, 1, 0};
      tbl[18] = '{100, 1, 100, 1, 0, 1, 0};
      tbl[19] = '{50,  1, 50,  0, 0, 1, 0};

      RST     = 1'b0;
      en      = 1'b0;
      Ref_Clk = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      chk_all_zero("reset");
      RST = 1'b1;
      en  = 1'b1;

      for (int i = 0; i < 20; i++) begin
         apply_vec($sformatf("tbl%0d", i), tbl[i]);
      end

      // Reference stops while locked: timeout exactly TMO cycles after the last capture.
      seen = 0;
      for (int i = 0; i < 200; i++) begin
         tick();
         if (ref_lost) begin
            seen = 1;
            break;
         end
      end
      chk("tmo_seen", seen, 1);
      chk("tmo_delay", since - last_cap, 100);
      chk("tmo_locked", int'(locked), 0);
      since = 1000;
      lock_seq("relock");

      // Single-cycle enable drop while locked.
      repeat (20) tick();
      en = 1'b0;
      tick();
      chk_all_zero("en_drop");
      en = 1'b1;
      lock_seq("en_rec");

      // Asynchronous reset pulse between clock edges while counting.
      repeat (20) tick();
      #2;
      RST = 1'b0;
      #1;
      chk_all_zero("rst_pulse");
      #1;
      RST = 1'b1;
      lock_seq("rst_rec");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
